// File: rtl/psum_accumulator.sv
// Partial-sum accumulation stage: seeds with zero or a bias, sums a programmable
// number of signed beats with saturation, and hands one result downstream.
module psum_accumulator #(
  parameter int unsigned DATA_WIDTH  = 20,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [COUNT_WIDTH-1:0] acc_len_i,
  input  logic                   bias_sel_i,
  input  logic [DATA_WIDTH-1:0]  bias_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATA_WIDTH-1:0]  data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_WIDTH-1:0]  out_data_o,
  output logic                   busy_o,
  output logic                   ovf_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_e;

  localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] len_q, len_d;
  logic                   ovf_q, ovf_d;

  logic [DATA_WIDTH:0]    sum_c;
  logic [DATA_WIDTH-1:0]  sat_c;
  logic [DATA_WIDTH-1:0]  seed_c;
  logic                   clamp_c;
  logic                   last_beat_c;

  // One guard bit catches signed overflow; the top two bits disagree only on overflow.
  always_comb begin
    sum_c   = {acc_q[DATA_WIDTH-1], acc_q} + {data_i[DATA_WIDTH-1], data_i};
    clamp_c = 1'b0;
    sat_c   = sum_c[DATA_WIDTH-1:0];
    if (sum_c[DATA_WIDTH:DATA_WIDTH-1] == 2'b01) begin
      clamp_c = 1'b1;
      sat_c   = MAX_VAL;
    end else if (sum_c[DATA_WIDTH:DATA_WIDTH-1] == 2'b10) begin
      clamp_c = 1'b1;
      sat_c   = MIN_VAL;
    end
  end

  assign seed_c      = bias_sel_i ? bias_i : '0;
  assign last_beat_c = (cnt_q == len_q - COUNT_WIDTH'(1));

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d = acc_len_i;
          acc_d = seed_c;
          cnt_d = '0;
          ovf_d = 1'b0;
          if (acc_len_i == '0) begin
            out_data_d = seed_c;
            state_d    = OUTPUT;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (in_valid_i) begin
          acc_d = sat_c;
          cnt_d = cnt_q + COUNT_WIDTH'(1);
          ovf_d = ovf_q | clamp_c;
          if (last_beat_c) begin
            out_data_d = sat_c;
            state_d    = OUTPUT;
          end
        end
      end
      OUTPUT: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      out_data_q <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
    end
  end

  // Handshake and status flags decode straight from the state register.
  assign in_ready_o  = (state_q == ACCUM);
  assign out_valid_o = (state_q == OUTPUT);
  assign busy_o      = (state_q != IDLE);
  assign out_data_o  = out_data_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed self-checking bench for psum_accumulator with hand-computed expectations.
module tb_psum_accumulator;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  acc_len_i = '0;
  logic        bias_sel_i = 1'b0;
  logic [19:0] bias_i = '0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [19:0] data_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [19:0] out_data_o;
  logic        busy_o;
  logic        ovf_o;

  int checks = 0;
  int failures = 0;

  localparam logic [19:0] SAT_MAX = 20'h7FFFF;
  localparam logic [19:0] SAT_MIN = 20'h80000;

  psum_accumulator #(.DATA_WIDTH(20), .COUNT_WIDTH(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .acc_len_i   (acc_len_i),
    .bias_sel_i  (bias_sel_i),
    .bias_i      (bias_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .data_i      (data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .busy_o      (busy_o),
    .ovf_o       (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #2 rst_i = 1'b1;
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_in_ready", 32'(in_ready_o), 32'd0);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_out_data", 32'(out_data_o), 32'd0);
    check("rst_ovf", 32'(ovf_o), 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy_o), 32'd0);

    // Basic sum 1+2+3+4
    start_i = 1'b1; acc_len_i = 8'd4; bias_sel_i = 1'b0;
    tick();
    start_i = 1'b0;
    check("basic_in_ready", 32'(in_ready_o), 32'd1);
    in_valid_i = 1'b1;
    data_i = 20'd1; tick();
    data_i = 20'd2; tick();
    data_i = 20'd3; tick();
    check("basic_no_early_valid", 32'(out_valid_o), 32'd0);
    data_i = 20'd4; tick();
    in_valid_i = 1'b0;
    check("basic_in_ready_fall", 32'(in_ready_o), 32'd0);
    check("basic_out_valid", 32'(out_valid_o), 32'd1);
    check("basic_out_data", 32'(out_data_o), 32'd10);
    check("basic_ovf", 32'(ovf_o), 32'd0);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("basic_idle_busy", 32'(busy_o), 32'd0);
    check("basic_idle_hold_data", 32'(out_data_o), 32'd10);

    // Bias 100, beats -30 and 5 with gaps, then backpressure
    start_i = 1'b1; acc_len_i = 8'd2; bias_sel_i = 1'b1; bias_i = 20'd100;
    tick();
    start_i = 1'b0;
    in_valid_i = 1'b1; data_i = -20'sd30; tick();
    in_valid_i = 1'b0; data_i = 20'd999;
    tick(); tick();
    check("gap_in_ready", 32'(in_ready_o), 32'd1);
    check("gap_no_valid", 32'(out_valid_o), 32'd0);
    in_valid_i = 1'b1; data_i = 20'd5; tick();
    in_valid_i = 1'b0;
    check("bias_out_valid", 32'(out_valid_o), 32'd1);
    check("bias_out_data", 32'(out_data_o), 32'd75);
    start_i = 1'b1; acc_len_i = 8'd5; bias_sel_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 32'(out_valid_o), 32'd1);
      check("stall_data", 32'(out_data_o), 32'd75);
    end
    // start held through the handshake cycle must be ignored
    out_ready_i = 1'b1;
    tick();
    start_i = 1'b0; out_ready_i = 1'b0;
    check("hs_start_ignored_busy", 32'(busy_o), 32'd0);
    check("hs_out_valid_low", 32'(out_valid_o), 32'd0);

    // Positive saturation: 524000 + 200 + 200 clamps to 524287
    start_i = 1'b1; acc_len_i = 8'd2; bias_sel_i = 1'b1; bias_i = 20'd524000;
    tick();
    start_i = 1'b0;
    in_valid_i = 1'b1; data_i = 20'd200; tick();
    check("sat_pos_no_ovf_yet", 32'(ovf_o), 32'd0);
    tick();
    in_valid_i = 1'b0;
    check("sat_pos_data", 32'(out_data_o), 32'(SAT_MAX));
    check("sat_pos_ovf", 32'(ovf_o), 32'd1);
    out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
    check("sat_ovf_sticky_idle", 32'(ovf_o), 32'd1);

    // Negative saturation; ovf clears at the start
    start_i = 1'b1; acc_len_i = 8'd2; bias_sel_i = 1'b0; bias_i = 20'd0;
    tick();
    start_i = 1'b0;
    check("ovf_cleared_at_start", 32'(ovf_o), 32'd0);
    in_valid_i = 1'b1; data_i = SAT_MIN; tick();
    check("sat_neg_first_no_ovf", 32'(ovf_o), 32'd0);
    tick();
    in_valid_i = 1'b0;
    check("sat_neg_data", 32'(out_data_o), 32'(SAT_MIN));
    check("sat_neg_ovf", 32'(ovf_o), 32'd1);
    out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;

    // Zero length: seed goes straight out, input beats ignored
    start_i = 1'b1; acc_len_i = 8'd0; bias_sel_i = 1'b1; bias_i = 20'd7;
    in_valid_i = 1'b1; data_i = 20'd55;
    tick();
    start_i = 1'b0;
    check("zero_out_valid", 32'(out_valid_o), 32'd1);
    check("zero_in_ready", 32'(in_ready_o), 32'd0);
    check("zero_out_data", 32'(out_data_o), 32'd7);
    check("zero_ovf", 32'(ovf_o), 32'd0);
    out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
    in_valid_i = 1'b0;
    check("zero_idle_data", 32'(out_data_o), 32'd7);
    check("zero_idle_busy", 32'(busy_o), 32'd0);

    // Abort mid-accumulation with reset
    start_i = 1'b1; acc_len_i = 8'd3; bias_sel_i = 1'b0;
    tick();
    start_i = 1'b0;
    in_valid_i = 1'b1; data_i = 20'd50; tick();
    in_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_out_valid", 32'(out_valid_o), 32'd0);
    check("abort_out_data", 32'(out_data_o), 32'd0);
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_valid", 32'(out_valid_o), 32'd0);
    end

    // Fresh len=1 run after abort
    start_i = 1'b1; acc_len_i = 8'd1; bias_sel_i = 1'b0;
    tick();
    start_i = 1'b0;
    in_valid_i = 1'b1; data_i = 20'd9; tick();
    in_valid_i = 1'b0;
    check("after_abort_valid", 32'(out_valid_o), 32'd1);
    check("after_abort_data", 32'(out_data_o), 32'd9);
    out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
    check("after_abort_idle", 32'(busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Sequential partial-sum accumulation stage directly downstream of the 2:1 psum select mux in the PE datapath.
- Consumes a stream of DATA_WIDTH-bit signed values (the mux output) over a valid/ready handshake.
- Seeds the accumulator with zero or an external bias, sums a programmable number of beats with signed saturation, and emits one result over an output valid/ready handshake.

Parameters:
- DATA_WIDTH, 20: width of input values, bias and result, signed two's complement.
- COUNT_WIDTH, 8: width of the beat-count configuration and internal counter.

Ports:
- clk_i, input, 1: clock, rising edge.
- rst_i, input, 1: reset, asynchronous, active-high.
- start_i, input, 1: begin a new accumulation; sampled only in IDLE.
- acc_len_i, input, COUNT_WIDTH: number of input beats to accumulate; latched on accepted start.
- bias_sel_i, input, 1: 1 = seed accumulator with bias_i, 0 = seed with 0; latched on accepted start.
- bias_i, input, DATA_WIDTH: signed seed value.
- in_valid_i, input, 1: data_i valid.
- in_ready_o, output, 1: block accepts data_i.
- data_i, input, DATA_WIDTH: signed value from the upstream mux.
- out_valid_o, output, 1: result valid.
- out_ready_i, input, 1: consumer accepts result.
- out_data_o, output, DATA_WIDTH: signed accumulated result.
- busy_o, output, 1: high whenever state is not IDLE.
- ovf_o, output, 1: sticky saturation flag for the current or most recent accumulation.

Behaviour:
- Reset (rst_i high, asynchronous): state goes to IDLE. Accumulator, counter, out_data_o, out_valid_o, in_ready_o, busy_o and ovf_o all go to 0. Reset mid-operation aborts the accumulation with no output produced.
- States are IDLE, ACCUM and OUTPUT, held in a registered state. in_ready_o = (state == ACCUM), out_valid_o = (state == OUTPUT), busy_o = (state != IDLE); all three are decoded from the state register only.
- IDLE:
  - start_i high with acc_len_i != 0: on that edge, latch the length, set acc to bias_i (bias_sel_i = 1) or 0, clear the counter, clear ovf_o, go to ACCUM.
  - start_i high with acc_len_i == 0: load the seed and clear ovf_o the same way, then go straight to OUTPUT.
- ACCUM:
  - Each beat with in_valid_i & in_ready_o: acc <= sat(acc + data_i) and counter increments.
  - The beat accepted while counter == len-1 moves the state to OUTPUT.
  - Gaps in in_valid_i stall without changing state.
- Arithmetic: the sum is computed at DATA_WIDTH+1 bits, then clamped to the range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Any clamp sets ovf_o, which stays set until the next accepted start.
- OUTPUT:
  - out_data_o = acc.
  - out_data_o and out_valid_o stay stable while out_ready_i is low.
  - out_valid_o & out_ready_i moves the state to IDLE on that edge.
- Latency: out_valid_o asserts in the cycle after the last input beat is accepted.
- start_i is ignored outside IDLE, including in the cycle of the output handshake. The next start is accepted no earlier than the first IDLE cycle.
- Minimum period per result: len+2 cycles.
- out_data_o keeps its last value in IDLE.
- in_valid_i is ignored in IDLE and in OUTPUT; no beat is consumed in either state.

Test Plan:
- Reset: assert rst_i mid-cycle without a clock edge -> all outputs are 0 immediately. Release rst_i -> state is IDLE and busy_o = 0.
- Basic sum: start with len=4, bias_sel=0; feed data 1, 2, 3, 4 back-to-back -> in_ready_o falls and out_valid_o rises one cycle after the 4th beat, out_data_o = 10, ovf_o = 0; handshake -> IDLE.
- Bias, gaps and backpressure: bias_sel=1, bias=100, len=2; feed -30, then 5, with 2 idle cycles between them -> out_data_o = 75. Hold out_ready_i low for 3 cycles -> out_valid_o and out_data_o stay stable; start_i pulsed meanwhile is ignored.
- Saturation: bias=524000, len=2, data 200, 200 -> out_data_o = 524287, ovf_o = 1. Then bias=0, len=2, data -524288, -524288 -> out_data_o = -524288, ovf_o = 1; ovf_o cleared at that second start.
- Zero length: len=0, bias_sel=1, bias=7 -> out_valid_o the cycle after start, out_data_o = 7, no input beat consumed.
- Abort: len=3; after 1 accepted beat, pulse rst_i -> IDLE, out_valid_o never asserts. A following len=1 run with data 9 -> 9.
